storebuf_gen: RTL
=================

STOREBUF_GEN -- requirements
Module: storebuf_gen

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning entry count (power of two, at least 4).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning store/load address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning data width (multiple of 8).
REQ-004 The block SHALL have parameter TAG_W, default 4, meaning speculation tag width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: port clk, input, 1 bit; port reset, input, 1 bit.
REQ-006 The store-allocate ports SHALL be: st_valid in 1; st_ready out 1; st_addr in ADDR_W; st_data in DATA_W; st_spec in 1; st_tag in TAG_W; st_strb in DATA_W/8 (present only with the macro).
REQ-007 The remaining control ports SHALL be: st_com in 1; prsuccess in 1; prmiss in 1; prtag in TAG_W; spectagfix in TAG_W.
REQ-008 The retire ports SHALL be: ret_valid out 1; ret_ready in 1; ret_addr out ADDR_W; ret_data out DATA_W; ret_strb out DATA_W/8 (macro only).
REQ-009 The load ports SHALL be: ld_req in 1; ld_addr in ADDR_W; ld_hit out 1; ld_data out DATA_W; ld_conflict out 1 (macro only).
REQ-010 The status ports SHALL be: full out 1; empty out 1; count out $clog2(DEPTH)+1.

Function
REQ-011 The entries SHALL form a circular queue with pointers tail (allocate), comptr (commit) and head (retire), each $clog2(DEPTH) bits wide and wrapping modulo DEPTH.
REQ-012 st_ready SHALL be ~full & ~prmiss; an allocate occurs on st_valid & st_ready, writes entry[tail] with valid=1, completed=0, specbit=st_spec and tag=st_tag, and sets tail to tail+1.
REQ-013 On st_com & ~prmiss, entry[comptr].completed SHALL be set and comptr SHALL advance; st_com SHALL be ignored if entry[comptr] is invalid or is being allocated in the same cycle.
REQ-014 ret_valid SHALL be valid[head] & completed[head] & ~prmiss, and ret_addr/ret_data SHALL show entry[head] combinationally.
REQ-015 On ret_valid & ret_ready, entry[head] SHALL be cleared and head SHALL advance; a simultaneous allocate and retire SHALL leave count unchanged.
REQ-016 full SHALL equal count==DEPTH, and empty SHALL equal count==0.
REQ-017 On prmiss, every entry with specbit=1 and (tag & spectagfix)!=0 SHALL be invalidated in one cycle, and tail SHALL become the slot after the youngest surviving entry, or head if none survive.
REQ-018 Killed entries are always the youngest contiguous run; the bench SHALL NOT drive other patterns.
REQ-019 On prsuccess without prmiss, specbit SHALL be cleared in every entry whose tag==prtag; an entry allocated in the same cycle SHALL keep st_spec.
REQ-020 If prmiss and prsuccess are asserted together, prmiss SHALL win and all specbits SHALL clear.
REQ-021 On ld_req, the block SHALL select the youngest valid entry (searching backwards from tail-1 toward head) whose addr==ld_addr.
REQ-022 The load result SHALL be registered: ld_hit/ld_data appear exactly 1 cycle after ld_req, and ld_hit SHALL be 0 in cycles without a prior ld_req.
REQ-023 A load SHALL NOT see a store allocated in the same cycle.
REQ-024 count SHALL be derived from the valid bits or tracked arithmetically, and SHALL never exceed DEPTH.

Reset
REQ-025 On reset, all pointers, valid, completed, specbit, count, ld_hit and ld_conflict SHALL be 0, with empty=1, full=0, ret_valid=0 and st_ready=1 in the following cycle.
REQ-026 The entry data/addr/tag arrays SHALL NOT be reset.
REQ-027 Reset asserted mid-operation SHALL override every other input in that cycle.

Configuration
REQ-028 With macro STOREBUF_BYTE_MASK_EN defined, each entry SHALL store st_strb, and retire SHALL present ret_strb.
REQ-029 With STOREBUF_BYTE_MASK_EN defined, the load hit SHALL require the youngest matching entry's strb to be all ones; otherwise ld_hit=0 and ld_conflict=1 are registered in the same cycle slot.
REQ-030 Without STOREBUF_BYTE_MASK_EN, the strb and conflict ports SHALL be absent and every store SHALL be a full word.

Structure
REQ-031 Package storebuf_pkg SHALL hold the default parameter constants and the entry typedef (addr, data, tag, strb).
REQ-032 Sub-module storebuf_youngest_find SHALL implement the rotate-by-tail priority search used for load match (REQ-021) and for the prmiss tail recompute (REQ-017).

Verification (DEPTH=16, ADDR_W=16, DATA_W=32)
REQ-033 Fill: 16 allocates, no commit -> full=1, st_ready=0, count=16; a 17th st_valid is dropped.
REQ-034 Wrap: allocate/commit/retire 40 stores with ret_ready=1 -> ret_addr order equals allocate order across wrap-around, and count returns to 0.
REQ-035 Forward: store A=0x0040 with D=0x11 then A=0x0040 with D=0x22, then ld_req A=0x0040 -> next cycle ld_hit=1, ld_data=0x22.
REQ-036 Kill: 3 non-speculative stores followed by 2 stores with tag=0b0100, then prmiss with spectagfix=0b0100 -> count=3, tail=head+3, and a load to a killed address misses.
REQ-037 prsuccess with prtag=0b0100 before the prmiss of REQ-036 -> no entries are killed and count=5.
REQ-038 Byte mask (STOREBUF_BYTE_MASK_EN defined): a store with strb=0b0011, then a load to the same address -> ld_hit=0, ld_conflict=1.

Source files
------------

// File: rtl/storebuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : storebuf_pkg
// Description : Default parameter constants and the reference entry layout
//               shared by the store buffer and its priority-search helper.
// Revision    : 1.0 - initial release
// ============================================================================
package storebuf_pkg;

   localparam int DEF_DEPTH  = 16;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_TAG_W  = 4;
   localparam int DEF_STRB_W = DEF_DATA_W / 8;

   // Reference layout of one buffer entry at the default widths.
   // The top keeps each field in its own array so every width can follow the
   // module parameters.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_TAG_W-1:0]  tag;
      logic [DEF_STRB_W-1:0] strb;
   } entry_t;

endpackage
`default_nettype wire

// File: rtl/storebuf_youngest_find.sv
`default_nettype none
// ============================================================================
// Module      : storebuf_youngest_find
// Description : Finds the youngest set bit of a circular match vector,
//               scanning backwards from start-1 (the newest slot) across all
//               DEPTH slots.
// Revision    : 1.0 - initial release
// ============================================================================
module storebuf_youngest_find #(
   parameter int DEPTH = 16
) (
   input  logic [DEPTH-1:0]         match,
   input  logic [$clog2(DEPTH)-1:0] start,
   output logic                     found,
   output logic [$clog2(DEPTH)-1:0] idx
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] pos;

   // Oldest candidate first, so the slot nearest start-1 overrides and wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         pos = start - PW'(1) - PW'(i);
         if (match[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/storebuf_gen.sv
`default_nettype none
// ============================================================================
// Module      : storebuf_gen
// Description : Speculative store buffer. Circular queue with allocate,
//               commit and retire pointers, tag-based speculation kill and
//               resolve, and a registered youngest-match load forward.
//               Optional byte masks: define STOREBUF_BYTE_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module storebuf_gen
   import storebuf_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int TAG_W  = DEF_TAG_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_data,
   input  logic                     st_spec,
   input  logic [TAG_W-1:0]         st_tag,
`ifdef STOREBUF_BYTE_MASK_EN
   input  logic [DATA_W/8-1:0]      st_strb,
`endif
   input  logic                     st_com,
   input  logic                     prsuccess,
   input  logic                     prmiss,
   input  logic [TAG_W-1:0]         prtag,
   input  logic [TAG_W-1:0]         spectagfix,
   output logic                     ret_valid,
   input  logic                     ret_ready,
   output logic [ADDR_W-1:0]        ret_addr,
   output logic [DATA_W-1:0]        ret_data,
`ifdef STOREBUF_BYTE_MASK_EN
   output logic [DATA_W/8-1:0]      ret_strb,
`endif
   input  logic                     ld_req,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic                     ld_hit,
   output logic [DATA_W-1:0]        ld_data,
`ifdef STOREBUF_BYTE_MASK_EN
   output logic                     ld_conflict,
`endif
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0]  valid, completed, specbit;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [TAG_W-1:0]  tag_mem  [DEPTH];
`ifdef STOREBUF_BYTE_MASK_EN
   logic [DATA_W/8-1:0] strb_mem [DEPTH];
`endif

   logic [PW-1:0]    tail, comptr, head, new_tail, surv_idx, ld_idx;
   logic [DEPTH-1:0] kill, survive, ld_match;
   logic             alloc, commit, retire, surv_found, ld_found, ld_full_word;

   // Occupancy comes straight from the valid bits, so it can never exceed DEPTH.
   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) count = count + CW'(valid[i]);
   end

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign st_ready  = ~full & ~prmiss;
   assign alloc     = st_valid & st_ready;
   // A slot that is being allocated this cycle cannot also be committed.
   assign commit    = st_com & ~prmiss & valid[comptr] & ~completed[comptr]
                      & ~(alloc & (tail == comptr));
   assign ret_valid = valid[head] & completed[head] & ~prmiss;
   assign retire    = ret_valid & ret_ready;
   assign ret_addr  = addr_mem[head];
   assign ret_data  = data_mem[head];
`ifdef STOREBUF_BYTE_MASK_EN
   assign ret_strb     = strb_mem[head];
   assign ld_full_word = &strb_mem[ld_idx];
`else
   assign ld_full_word = 1'b1;
`endif

   // Per-entry kill and load-match vectors, built from registered state only
   // so a load never sees a same-cycle allocate.
   always_comb begin
      kill     = '0;
      ld_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill[i]     = valid[i] & specbit[i] & (|(tag_mem[i] & spectagfix));
         ld_match[i] = valid[i] & (addr_mem[i] == ld_addr);
      end
   end

   assign survive  = valid & ~kill;
   assign new_tail = surv_found ? surv_idx + PW'(1) : head;

   storebuf_youngest_find #(.DEPTH(DEPTH)) u_kill_find (
      .match (survive),
      .start (tail),
      .found (surv_found),
      .idx   (surv_idx)
   );

   storebuf_youngest_find #(.DEPTH(DEPTH)) u_ld_find (
      .match (ld_match),
      .start (tail),
      .found (ld_found),
      .idx   (ld_idx)
   );

   // Pointer and per-entry status update; a misprediction preempts all traffic.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid     <= '0;
         completed <= '0;
         specbit   <= '0;
         tail      <= '0;
         comptr    <= '0;
         head      <= '0;
      end else if (prmiss) begin
         valid     <= valid & ~kill;
         completed <= completed & ~kill;
         specbit   <= '0;
         tail      <= new_tail;
         // Pull the commit pointer back if it sat inside the killed run.
         if (kill[comptr] || ((comptr == tail) && !full)) comptr <= new_tail;
      end else begin
         if (prsuccess) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (tag_mem[i] == prtag) specbit[i] <= 1'b0;
            end
         end
         if (commit) begin
            completed[comptr] <= 1'b1;
            comptr            <= comptr + PW'(1);
         end
         if (retire) begin
            valid[head]     <= 1'b0;
            completed[head] <= 1'b0;
            specbit[head]   <= 1'b0;
            head            <= head + PW'(1);
         end
         // Placed last so a fresh entry keeps st_spec over a same-cycle resolve.
         if (alloc) begin
            valid[tail]     <= 1'b1;
            completed[tail] <= 1'b0;
            specbit[tail]   <= st_spec;
            tail            <= tail + PW'(1);
         end
      end
   end

   // Entry payload capture; intentionally not reset.
   always_ff @(posedge clk) begin
      if (alloc && !reset) begin
         addr_mem[tail] <= st_addr;
         data_mem[tail] <= st_data;
         tag_mem[tail]  <= st_tag;
`ifdef STOREBUF_BYTE_MASK_EN
         strb_mem[tail] <= st_strb;
`endif
      end
   end

   // Registered load forward result, one cycle after the request.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_hit  <= 1'b0;
         ld_data <= '0;
`ifdef STOREBUF_BYTE_MASK_EN
         ld_conflict <= 1'b0;
`endif
      end else begin
         ld_hit <= ld_req & ld_found & ld_full_word;
`ifdef STOREBUF_BYTE_MASK_EN
         ld_conflict <= ld_req & ld_found & ~ld_full_word;
`endif
         if (ld_req) ld_data <= data_mem[ld_idx];
      end
   end

endmodule
`default_nettype wire
